// File: rtl/dda_lane_scheduler.sv
// dda_lane_scheduler: shares ray-traversal jobs across NLANES dda_stepper lanes.
// Jobs are dispatched round-robin to free lanes, and results are collected
// round-robin into one registered output slot tagged with job tag and lane.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and ready here
// is computed from registered state plus the peer's valid/ready only.
module dda_lane_scheduler #(
    parameter int NLANES = 4,
    parameter int TAGW   = 8,
    localparam int RESW  = 29,
    localparam int LW    = $clog2(NLANES),
    localparam int CW    = $clog2(NLANES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [TAGW-1:0]          job_tag,
    output logic [NLANES-1:0]        lane_load,
    output logic [NLANES-1:0]        lane_active,
    input  logic [NLANES-1:0]        lane_res_valid,
    output logic [NLANES-1:0]        lane_res_ready,
    input  logic [NLANES*RESW-1:0]   lane_res_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RESW-1:0]          out_data,
    output logic [TAGW-1:0]          out_tag,
    output logic [LW-1:0]            out_lane,
    output logic [CW-1:0]            inflight,
    output logic                     busy
);

    // Per-lane state: a lane is BUSY while active_q is set, FREE otherwise.
    logic [NLANES-1:0] active_q, active_d;
    logic [TAGW-1:0]   tag_q [NLANES];
    logic [TAGW-1:0]   tag_d [NLANES];
    logic [LW-1:0]     disp_ptr_q, disp_ptr_d;
    logic [LW-1:0]     res_ptr_q, res_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [RESW-1:0]   out_data_q, out_data_d;
    logic [TAGW-1:0]   out_tag_q, out_tag_d;
    logic [LW-1:0]     out_lane_q, out_lane_d;
    logic [CW-1:0]     inflight_q, inflight_d;

    logic              disp_found, accept;
    logic [LW-1:0]     disp_lane;
    logic              res_found, res_take, slot_open;
    logic [LW-1:0]     res_lane;
    logic [NLANES-1:0] eligible;
    logic [RESW-1:0]   res_data_sel;
    logic [TAGW-1:0]   res_tag_sel;

    // Lane index base+k with wrap at NLANES (NLANES need not be a power of two).
    function automatic logic [LW-1:0] lane_at(input logic [LW-1:0] base, input int k);
        logic [LW:0] s;
        s = {1'b0, base} + (LW+1)'(k);
        if (s >= (LW+1)'(NLANES)) s = s - (LW+1)'(NLANES);
        return s[LW-1:0];
    endfunction

    // Dispatch pick: first free lane scanning upward from disp_ptr.
    always_comb begin
        disp_found = 1'b0;
        disp_lane  = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (!disp_found && !active_q[lane_at(disp_ptr_q, k)]) begin
                disp_found = 1'b1;
                disp_lane  = lane_at(disp_ptr_q, k);
            end
        end
    end

    // Result grant: first active lane with a result, scanning from res_ptr.
    always_comb begin
        eligible  = lane_res_valid & active_q;
        res_found = 1'b0;
        res_lane  = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (!res_found && eligible[lane_at(res_ptr_q, k)]) begin
                res_found = 1'b1;
                res_lane  = lane_at(res_ptr_q, k);
            end
        end
    end

    // Mux the granted lane's result and stored tag.
    always_comb begin
        res_data_sel = '0;
        res_tag_sel  = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (res_lane == LW'(i)) begin
                res_data_sel = lane_res_data[i*RESW +: RESW];
                res_tag_sel  = tag_q[i];
            end
        end
    end

    // Handshake outputs; job_ready comes from state only, no path from job_valid.
    always_comb begin
        job_ready      = |(~active_q);
        accept         = job_valid & job_ready;
        slot_open      = !out_valid_q | out_ready;
        res_take       = slot_open & res_found;
        lane_load      = accept   ? (NLANES'(1) << disp_lane) : '0;
        lane_res_ready = res_take ? (NLANES'(1) << res_lane)  : '0;
    end

    // Next-state: dispatch sets a lane, retire clears one; they never collide
    // because dispatch only targets lanes that are free at cycle start.
    always_comb begin
        active_d    = active_q;
        tag_d       = tag_q;
        disp_ptr_d  = disp_ptr_q;
        res_ptr_d   = res_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_lane_d  = out_lane_q;
        inflight_d  = inflight_q;
        if (accept) begin
            active_d[disp_lane] = 1'b1;
            tag_d[disp_lane]    = job_tag;
            disp_ptr_d          = lane_at(disp_lane, 1);
        end
        if (res_take) begin
            active_d[res_lane] = 1'b0;
            res_ptr_d          = lane_at(res_lane, 1);
            out_valid_d        = 1'b1;
            out_data_d         = res_data_sel;
            out_tag_d          = res_tag_sel;
            out_lane_d         = res_lane;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case ({accept, res_take})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q    <= '0;
            for (int i = 0; i < NLANES; i++) tag_q[i] <= '0;
            disp_ptr_q  <= '0;
            res_ptr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_lane_q  <= '0;
            inflight_q  <= '0;
        end else begin
            active_q    <= active_d;
            tag_q       <= tag_d;
            disp_ptr_q  <= disp_ptr_d;
            res_ptr_q   <= res_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_lane_q  <= out_lane_d;
            inflight_q  <= inflight_d;
        end
    end

    // Registered outputs.
    always_comb begin
        lane_active = active_q;
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        out_tag     = out_tag_q;
        out_lane    = out_lane_q;
        inflight    = inflight_q;
        busy        = (inflight_q != '0) | out_valid_q;
    end

endmodule

// File: tb/tb_dda_lane_scheduler.sv
// Directed bench for dda_lane_scheduler (NLANES=4, TAGW=8).
module tb_dda_lane_scheduler;

    logic         clock;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [7:0]   job_tag;
    logic [3:0]   lane_load;
    logic [3:0]   lane_active;
    logic [3:0]   lane_res_valid;
    logic [3:0]   lane_res_ready;
    logic [115:0] lane_res_data;
    logic         out_valid;
    logic         out_ready;
    logic [28:0]  out_data;
    logic [7:0]   out_tag;
    logic [1:0]   out_lane;
    logic [2:0]   inflight;
    logic         busy;

    int errors = 0;
    int checks = 0;

    localparam logic [28:0] D0  = 29'h0ABC_DE1;
    localparam logic [28:0] D1  = 29'h1234_567;
    localparam logic [28:0] D2  = 29'h1FED_CBA;
    localparam logic [28:0] D3  = 29'h0555_AAA;
    localparam logic [28:0] D2B = 29'h1000_0F3;

    dda_lane_scheduler #(.NLANES(4), .TAGW(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_tag        (job_tag),
        .lane_load      (lane_load),
        .lane_active    (lane_active),
        .lane_res_valid (lane_res_valid),
        .lane_res_ready (lane_res_ready),
        .lane_res_data  (lane_res_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .out_lane       (out_lane),
        .inflight       (inflight),
        .busy           (busy)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_res(input int lane, input logic [28:0] d);
        lane_res_data[lane*29 +: 29] = d;
    endtask

    // Directed stimulus
    initial begin
        reset = 1'b0; job_valid = 1'b0; job_tag = 8'h00;
        lane_res_valid = 4'b0000; lane_res_data = '0; out_ready = 1'b1;
        #12;
        check("rst_job_ready", 64'(job_ready), 64'h1);
        check("rst_lane_load", 64'(lane_load), 64'h0);
        check("rst_res_ready", 64'(lane_res_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_inflight", 64'(inflight), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_active", 64'(lane_active), 64'h0);
        reset = 1'b1;
        tick();

        // Fill: tags 0x10..0x13 land on lanes 0..3
        for (int i = 0; i < 4; i++) begin
            job_valid = 1'b1; job_tag = 8'(8'h10 + i);
            #1;
            check("fill_job_ready", 64'(job_ready), 64'h1);
            check("fill_lane_load", 64'(lane_load), 64'(4'b0001 << i));
            tick();
        end
        job_valid = 1'b0;
        #1;
        check("full_job_ready", 64'(job_ready), 64'h0);
        check("full_inflight", 64'(inflight), 64'h4);
        check("full_active", 64'(lane_active), 64'hF);

        // Out-of-order: lane 2 finishes first, then lane 0
        repeat (3) tick();
        set_res(2, D2); lane_res_valid = 4'b0100;
        #1;
        check("ooo2_res_ready", 64'(lane_res_ready), 64'h4);
        tick();
        lane_res_valid = 4'b0000;
        check("ooo2_out_valid", 64'(out_valid), 64'h1);
        check("ooo2_out_tag", 64'(out_tag), 64'h12);
        check("ooo2_out_lane", 64'(out_lane), 64'h2);
        check("ooo2_out_data", 64'(out_data), 64'(D2));
        check("ooo2_active", 64'(lane_active), 64'hB);
        check("ooo2_inflight", 64'(inflight), 64'h3);
        tick();
        check("ooo2_drained", 64'(out_valid), 64'h0);
        repeat (3) tick();
        set_res(0, D0); lane_res_valid = 4'b0001;
        #1;
        check("ooo0_res_ready", 64'(lane_res_ready), 64'h1);
        tick();
        lane_res_valid = 4'b0000;
        check("ooo0_out_tag", 64'(out_tag), 64'h10);
        check("ooo0_out_lane", 64'(out_lane), 64'h0);
        check("ooo0_out_data", 64'(out_data), 64'(D0));
        check("ooo0_active", 64'(lane_active), 64'hA);
        check("ooo0_inflight", 64'(inflight), 64'h2);
        tick();

        // Refill lanes 0 and 2 (disp_ptr wrapped to 0, then skips busy lane 1)
        job_valid = 1'b1; job_tag = 8'h20;
        #1;
        check("refill_load_a", 64'(lane_load), 64'h1);
        tick();
        job_tag = 8'h21;
        #1;
        check("refill_load_b", 64'(lane_load), 64'h4);
        tick();
        job_valid = 1'b0;
        check("refill_inflight", 64'(inflight), 64'h4);

        // Retire lane 1, redispatch onto it the very next cycle
        set_res(1, D1); lane_res_valid = 4'b0010;
        #1;
        check("rr_res_ready", 64'(lane_res_ready), 64'h2);
        tick();
        lane_res_valid = 4'b0000;
        check("rr_out_tag", 64'(out_tag), 64'h11);
        check("rr_inflight", 64'(inflight), 64'h3);
        check("rr_job_ready", 64'(job_ready), 64'h1);
        job_valid = 1'b1; job_tag = 8'h22;
        #1;
        check("rr_lane_load", 64'(lane_load), 64'h2);
        tick();
        job_valid = 1'b0;
        check("rr_active", 64'(lane_active), 64'hF);
        check("rr_inflight_max", 64'(inflight), 64'h4);
        check("rr_drained", 64'(out_valid), 64'h0);

        // Simultaneous results from res_ptr=2: grants 2,3,0,1 back to back
        set_res(0, D0); set_res(1, D1); set_res(2, D2); set_res(3, D3);
        lane_res_valid = 4'b1111;
        #1;
        check("sim_res_ready_0", 64'(lane_res_ready), 64'h4);
        tick();
        check("sim_tag_0", 64'(out_tag), 64'h21);
        check("sim_lane_0", 64'(out_lane), 64'h2);
        check("sim_res_ready_1", 64'(lane_res_ready), 64'h8);
        tick();
        check("sim_valid_1", 64'(out_valid), 64'h1);
        check("sim_tag_1", 64'(out_tag), 64'h13);
        check("sim_data_1", 64'(out_data), 64'(D3));
        check("sim_res_ready_2", 64'(lane_res_ready), 64'h1);
        tick();
        check("sim_valid_2", 64'(out_valid), 64'h1);
        check("sim_tag_2", 64'(out_tag), 64'h20);
        check("sim_res_ready_3", 64'(lane_res_ready), 64'h2);
        tick();
        check("sim_valid_3", 64'(out_valid), 64'h1);
        check("sim_tag_3", 64'(out_tag), 64'h22);
        check("sim_lane_3", 64'(out_lane), 64'h1);
        check("sim_inflight", 64'(inflight), 64'h0);
        check("sim_ignore_inactive", 64'(lane_res_ready), 64'h0);
        tick();
        lane_res_valid = 4'b0000;
        check("sim_drained", 64'(out_valid), 64'h0);
        check("sim_busy", 64'(busy), 64'h0);

        // Backpressure: two lanes done, out_ready low for 10 cycles
        job_valid = 1'b1; job_tag = 8'h30;
        #1;
        check("bp_load_a", 64'(lane_load), 64'h4);
        tick();
        job_tag = 8'h31;
        #1;
        check("bp_load_b", 64'(lane_load), 64'h8);
        tick();
        job_valid = 1'b0;
        out_ready = 1'b0;
        set_res(2, D2B); set_res(3, D3); lane_res_valid = 4'b1100;
        #1;
        check("bp_first_grant", 64'(lane_res_ready), 64'h4);
        tick();
        for (int c = 0; c < 10; c++) begin
            check("bp_no_grant", 64'(lane_res_ready), 64'h0);
            check("bp_data_stable", 64'(out_data), 64'(D2B));
            check("bp_tag_stable", 64'(out_tag), 64'h30);
            check("bp_valid_hold", 64'(out_valid), 64'h1);
            tick();
        end
        check("bp_lane3_held", 64'(lane_active), 64'h8);
        out_ready = 1'b1;
        #1;
        check("bp_release_grant", 64'(lane_res_ready), 64'h8);
        tick();
        lane_res_valid = 4'b0000;
        check("bp_second_tag", 64'(out_tag), 64'h31);
        check("bp_second_lane", 64'(out_lane), 64'h3);
        check("bp_second_data", 64'(out_data), 64'(D3));
        tick();
        check("bp_drained", 64'(out_valid), 64'h0);

        // Async reset mid-traffic
        job_valid = 1'b1; job_tag = 8'h40;
        tick();
        job_tag = 8'h41;
        tick();
        job_valid = 1'b0;
        out_ready = 1'b0;
        set_res(0, D0); lane_res_valid = 4'b0001;
        tick();
        lane_res_valid = 4'b0000;
        check("pre_rst_out_valid", 64'(out_valid), 64'h1);
        check("pre_rst_active", 64'(lane_active), 64'h2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_active", 64'(lane_active), 64'h0);
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_tag", 64'(out_tag), 64'h0);
        check("arst_out_data", 64'(out_data), 64'h0);
        check("arst_out_lane", 64'(out_lane), 64'h0);
        check("arst_inflight", 64'(inflight), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_job_ready", 64'(job_ready), 64'h1);
        check("arst_lane_load", 64'(lane_load), 64'h0);
        check("arst_res_ready", 64'(lane_res_ready), 64'h0);
        #2;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        job_valid = 1'b1; job_tag = 8'h50;
        #1;
        check("post_rst_load", 64'(lane_load), 64'h1);
        tick();
        job_valid = 1'b0;
        check("post_rst_active", 64'(lane_active), 64'h1);
        check("post_rst_inflight", 64'(inflight), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
